// File: rtl/m_csr_unit_if.sv
// Signal bundle between the RV32I pipeline and the machine-mode CSR unit.
// The pipeline side drives through master; the CSR unit connects through slave.
interface m_csr_unit_if #(
    parameter int unsigned CAUSE_W = 4
) ();
    logic [11:0]        csr_addr;
    logic [31:0]        csr_out;
    logic [11:0]        csr_wr_addr;
    logic [1:0]         csr_op;
    logic [31:0]        csr_src;
    logic               illegal_csr;
    logic               instret;
    logic               irq_ext;
    logic               irq_timer;
    logic               irq_sw;
    logic               int_window;
    logic [31:0]        int_pc;
    logic               e_raised;
    logic [CAUSE_W-1:0] e_cause;
    logic [31:0]        e_pc;
    logic [31:0]        e_tval;
    logic               is_mret;
    logic               trap_taken;
    logic [31:0]        trap_pc;
    logic [31:0]        mepc_out;

    modport slave (
        input  csr_addr, csr_wr_addr, csr_op, csr_src, instret,
        input  irq_ext, irq_timer, irq_sw, int_window, int_pc,
        input  e_raised, e_cause, e_pc, e_tval, is_mret,
        output csr_out, illegal_csr, trap_taken, trap_pc, mepc_out
    );

    modport master (
        output csr_addr, csr_wr_addr, csr_op, csr_src, instret,
        output irq_ext, irq_timer, irq_sw, int_window, int_pc,
        output e_raised, e_cause, e_pc, e_tval, is_mret,
        input  csr_out, illegal_csr, trap_taken, trap_pc, mepc_out
    );
endinterface

// File: rtl/m_csr_unit.sv
// Machine-mode CSR file for RV32I: CSR read-modify-write, 64-bit cycle/instret counters,
// trap entry for exceptions and prioritised interrupts, and MRET.
module m_csr_unit #(
    parameter logic [31:0] HART_ID        = 32'd0,
    parameter logic [31:0] MISA_VAL       = 32'h4000_0100,
    parameter int unsigned CAUSE_W        = 4,
    parameter logic [31:0] MEPC_RESET     = 32'h0001_0000,
    parameter logic [31:0] MTVEC_RESET    = 32'h0000_0000,
    parameter bit          MTVEC_WRITABLE = 1'b1,
    parameter bit          HAS_COUNTERS   = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    m_csr_unit_if.slave bus
);
    localparam logic [11:0] ADDR_MVENDORID     = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID       = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID        = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID       = 12'hF14;
    localparam logic [11:0] ADDR_MSTATUS       = 12'h300;
    localparam logic [11:0] ADDR_MISA          = 12'h301;
    localparam logic [11:0] ADDR_MIE           = 12'h304;
    localparam logic [11:0] ADDR_MTVEC         = 12'h305;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] ADDR_MSCRATCH      = 12'h340;
    localparam logic [11:0] ADDR_MEPC          = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE        = 12'h342;
    localparam logic [11:0] ADDR_MTVAL         = 12'h343;
    localparam logic [11:0] ADDR_MIP           = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [3:0] CODE_MSI = 4'd3;
    localparam logic [3:0] CODE_MTI = 4'd7;
    localparam logic [3:0] CODE_MEI = 4'd11;

    // Architectural state; interrupt vectors are ordered {ext, timer, sw}.
    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [2:0]  r_mie;
    logic [2:0]  r_mip;
    logic [31:0] r_mtvec;
    logic [31:2] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [31:0] r_mscratch;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;
    logic        r_inhibit_cy;
    logic        r_inhibit_ir;

    logic [CAUSE_W-1:0] w_e_cause;
    logic [32:0] w_rd;
    logic [32:0] w_wr_old;
    logic        w_wr_hit;
    logic [31:0] w_wr_val;
    logic        w_eff_write;
    logic        w_read_only;
    logic        w_illegal;
    logic        w_wr_en;
    logic        w_wr_main;
    logic [2:0]  w_ip;
    logic        w_int_take;
    logic [3:0]  w_int_code;
    logic        w_trap;
    logic [31:0] w_base;
    logic [31:0] w_trap_pc;
    logic        w_cy_lo_wr;
    logic        w_cy_hi_wr;
    logic        w_ir_lo_wr;
    logic        w_ir_hi_wr;

    assign w_e_cause = bus.e_cause;

    // Returns {implemented, data}; unimplemented addresses yield all zeros.
    function automatic logic [32:0] f_read(input logic [11:0] a);
        logic [32:0] r;
        r = {1'b1, 32'd0};
        case (a)
            ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID: r[31:0] = 32'd0;
            ADDR_MHARTID:  r[31:0] = HART_ID;
            ADDR_MISA:     r[31:0] = MISA_VAL;
            ADDR_MSTATUS:  r[31:0] = {19'd0, 2'b11, 3'd0, r_mstatus_mpie, 3'd0,
                                      r_mstatus_mie, 3'd0};
            ADDR_MIE:      r[31:0] = {20'd0, r_mie[2], 3'd0, r_mie[1], 3'd0, r_mie[0], 3'd0};
            ADDR_MIP:      r[31:0] = {20'd0, r_mip[2], 3'd0, r_mip[1], 3'd0, r_mip[0], 3'd0};
            ADDR_MTVEC:    r[31:0] = r_mtvec;
            ADDR_MSCRATCH: r[31:0] = r_mscratch;
            ADDR_MEPC:     r[31:0] = {r_mepc, 2'b00};
            ADDR_MCAUSE:   r[31:0] = r_mcause;
            ADDR_MTVAL:    r[31:0] = r_mtval;
            ADDR_MCOUNTINHIBIT:
                r = HAS_COUNTERS ? {1'b1, 29'd0, r_inhibit_ir, 1'b0, r_inhibit_cy} : 33'd0;
            ADDR_MCYCLE, ADDR_CYCLE:
                r = HAS_COUNTERS ? {1'b1, r_mcycle[31:0]} : 33'd0;
            ADDR_MCYCLEH, ADDR_CYCLEH:
                r = HAS_COUNTERS ? {1'b1, r_mcycle[63:32]} : 33'd0;
            ADDR_MINSTRET, ADDR_INSTRET:
                r = HAS_COUNTERS ? {1'b1, r_minstret[31:0]} : 33'd0;
            ADDR_MINSTRETH, ADDR_INSTRETH:
                r = HAS_COUNTERS ? {1'b1, r_minstret[63:32]} : 33'd0;
            default:       r = 33'd0;
        endcase
        return r;
    endfunction

    assign w_rd        = f_read(bus.csr_addr);
    assign bus.csr_out = w_rd[31:0];

    assign w_wr_old = f_read(bus.csr_wr_addr);
    assign w_wr_hit = w_wr_old[32];

    always_comb begin
        w_wr_val = w_wr_old[31:0];
        case (bus.csr_op)
            OP_WRITE: w_wr_val = bus.csr_src;
            OP_SET:   w_wr_val = w_wr_old[31:0] | bus.csr_src;
            OP_CLEAR: w_wr_val = w_wr_old[31:0] & ~bus.csr_src;
            default:  w_wr_val = w_wr_old[31:0];
        endcase
    end

    // Set/clear with a zero mask is a pure read, so it may target read-only CSRs.
    assign w_eff_write = (bus.csr_op == OP_WRITE) || (bus.csr_op[1] && (bus.csr_src != 32'd0));
    assign w_read_only = (bus.csr_wr_addr[11:10] == 2'b11) ||
                         ((bus.csr_wr_addr == ADDR_MTVEC) && !MTVEC_WRITABLE);
    assign w_illegal   = (bus.csr_op != 2'b00) && (!w_wr_hit || (w_eff_write && w_read_only));
    assign bus.illegal_csr = w_illegal;

    assign w_wr_en   = (bus.csr_op != 2'b00) && w_eff_write && !w_illegal;
    assign w_wr_main = w_wr_en && !w_trap && !bus.is_mret;

    assign w_ip       = r_mip & r_mie;
    assign w_int_take = r_mstatus_mie && (w_ip != 3'b000) && bus.int_window && !bus.e_raised;

    always_comb begin
        w_int_code = CODE_MTI;
        if (w_ip[2]) begin
            w_int_code = CODE_MEI;
        end else if (w_ip[0]) begin
            w_int_code = CODE_MSI;
        end
    end

    assign w_trap         = bus.e_raised || w_int_take;
    assign w_base         = {r_mtvec[31:2], 2'b00};
    assign w_trap_pc      = (r_mtvec[0] && w_int_take) ? (w_base + {26'd0, w_int_code, 2'b00})
                                                       : w_base;
    assign bus.trap_taken = w_trap;
    assign bus.trap_pc    = w_trap_pc;
    assign bus.mepc_out   = {r_mepc, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= 3'b000;
            r_mip          <= 3'b000;
            r_mtvec        <= {MTVEC_RESET[31:2], 1'b0, MTVEC_RESET[0]};
            r_mepc         <= MEPC_RESET[31:2];
            r_mcause       <= 32'd0;
            r_mtval        <= 32'd0;
            r_inhibit_cy   <= 1'b0;
            r_inhibit_ir   <= 1'b0;
        end else begin
            r_mip <= {bus.irq_ext, bus.irq_timer, bus.irq_sw};
            if (w_trap) begin
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
                if (bus.e_raised) begin
                    r_mepc   <= bus.e_pc[31:2];
                    r_mcause <= 32'(w_e_cause);
                    r_mtval  <= bus.e_tval;
                end else begin
                    r_mepc   <= bus.int_pc[31:2];
                    r_mcause <= {1'b1, 27'd0, w_int_code};
                    r_mtval  <= 32'd0;
                end
            end else if (bus.is_mret) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else if (w_wr_main) begin
                case (bus.csr_wr_addr)
                    ADDR_MSTATUS: begin
                        r_mstatus_mie  <= w_wr_val[3];
                        r_mstatus_mpie <= w_wr_val[7];
                    end
                    ADDR_MIE:     r_mie   <= {w_wr_val[11], w_wr_val[7], w_wr_val[3]};
                    ADDR_MTVEC:   r_mtvec <= {w_wr_val[31:2], 1'b0, w_wr_val[0]};
                    ADDR_MEPC:    r_mepc  <= w_wr_val[31:2];
                    ADDR_MCAUSE:  r_mcause <= w_wr_val;
                    ADDR_MTVAL:   r_mtval  <= w_wr_val;
                    ADDR_MCOUNTINHIBIT: begin
                        r_inhibit_cy <= w_wr_val[0];
                        r_inhibit_ir <= w_wr_val[2];
                    end
                    default: ;
                endcase
            end
        end
    end

    // mscratch and the counters commit even when a trap or MRET wins the cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mscratch <= 32'd0;
        end else if (w_wr_en && (bus.csr_wr_addr == ADDR_MSCRATCH)) begin
            r_mscratch <= w_wr_val;
        end
    end

    assign w_cy_lo_wr = w_wr_en && (bus.csr_wr_addr == ADDR_MCYCLE);
    assign w_cy_hi_wr = w_wr_en && (bus.csr_wr_addr == ADDR_MCYCLEH);
    assign w_ir_lo_wr = w_wr_en && (bus.csr_wr_addr == ADDR_MINSTRET);
    assign w_ir_hi_wr = w_wr_en && (bus.csr_wr_addr == ADDR_MINSTRETH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcycle   <= 64'd0;
            r_minstret <= 64'd0;
        end else begin
            if (w_cy_lo_wr) begin
                r_mcycle[31:0] <= w_wr_val;
            end else if (w_cy_hi_wr) begin
                r_mcycle[63:32] <= w_wr_val;
            end else if (HAS_COUNTERS && !r_inhibit_cy) begin
                r_mcycle <= r_mcycle + 64'd1;
            end

            if (w_ir_lo_wr) begin
                r_minstret[31:0] <= w_wr_val;
            end else if (w_ir_hi_wr) begin
                r_minstret[63:32] <= w_wr_val;
            end else if (HAS_COUNTERS && !r_inhibit_ir && bus.instret) begin
                r_minstret <= r_minstret + 64'd1;
            end
        end
    end
endmodule

// File: tb/tb_m_csr_unit.sv
// Directed bench for m_csr_unit: stimulus queues expected values, a negedge monitor
// pops them and compares against the live DUT outputs.
module tb_m_csr_unit;
    localparam int K_OUT  = 0;
    localparam int K_ILL  = 1;
    localparam int K_TT   = 2;
    localparam int K_TPC  = 3;
    localparam int K_MEPC = 4;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;

    m_csr_unit_if #(.CAUSE_W(4)) bus ();

    m_csr_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_checks = 0;
        n_fail   = 0;
    end

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb_q.pop_front();
            case (e.kind)
                K_ILL:   act = {31'd0, bus.illegal_csr};
                K_TT:    act = {31'd0, bus.trap_taken};
                K_TPC:   act = bus.trap_pc;
                K_MEPC:  act = bus.mepc_out;
                default: act = bus.csr_out;
            endcase
            n_checks = n_checks + 1;
            if (act !== e.exp) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input int k, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    task automatic rd(input string n, input logic [11:0] a, input logic [31:0] v);
        bus.csr_addr = a;
        chk(n, K_OUT, v);
        cyc();
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] s);
        bus.csr_op      = op;
        bus.csr_wr_addr = a;
        bus.csr_src     = s;
        cyc();
        bus.csr_op = 2'b00;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.csr_addr    = 12'h000;
        bus.csr_wr_addr = 12'h000;
        bus.csr_op      = 2'b00;
        bus.csr_src     = 32'd0;
        bus.instret     = 1'b0;
        bus.irq_ext     = 1'b0;
        bus.irq_timer   = 1'b0;
        bus.irq_sw      = 1'b0;
        bus.int_window  = 1'b0;
        bus.int_pc      = 32'd0;
        bus.e_raised    = 1'b0;
        bus.e_cause     = 4'd0;
        bus.e_pc        = 32'd0;
        bus.e_tval      = 32'd0;
        bus.is_mret     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset values; mcycle counts 0,1,2,3 over these reads.
        chk("rst_mepc_out", K_MEPC, 32'h0001_0000);
        chk("rst_trap_taken", K_TT, 32'd0);
        chk("rst_illegal", K_ILL, 32'd0);
        rd("rst_mepc", 12'h341, 32'h0001_0000);
        rd("rst_mtvec", 12'h305, 32'h0000_0000);
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_mcycle", 12'hB00, 32'd3);
        rd("rst_misa", 12'h301, 32'h4000_0100);
        rd("rst_mip", 12'h344, 32'd0);
        rd("rst_unimpl", 12'h7C0, 32'd0);

        // Read-modify-write on mscratch.
        wr(2'b01, 12'h340, 32'hF0F0_00FF);
        wr(2'b10, 12'h340, 32'h0000_FF00);
        bus.csr_addr = 12'h340;
        chk("no_bypass", K_OUT, 32'hF0F0_FFFF);
        wr(2'b11, 12'h340, 32'h0000_00F0);
        rd("rmw_result", 12'h340, 32'hF0F0_FF0F);

        bus.csr_op = 2'b01; bus.csr_wr_addr = 12'hF11; bus.csr_src = 32'h1234;
        chk("ill_ro_write", K_ILL, 32'd1);
        cyc();
        bus.csr_op = 2'b10; bus.csr_wr_addr = 12'hF11; bus.csr_src = 32'd0;
        chk("ro_set_zero", K_ILL, 32'd0);
        cyc();
        bus.csr_op = 2'b10; bus.csr_wr_addr = 12'h7C0; bus.csr_src = 32'd0;
        chk("ill_unimpl", K_ILL, 32'd1);
        cyc();
        bus.csr_op = 2'b01; bus.csr_wr_addr = 12'hC00; bus.csr_src = 32'h5;
        chk("ill_shadow", K_ILL, 32'd1);
        cyc();
        bus.csr_op = 2'b01; bus.csr_wr_addr = 12'h344; bus.csr_src = 32'hFFFF_FFFF;
        chk("mip_write_legal", K_ILL, 32'd0);
        cyc();
        bus.csr_op = 2'b00;
        rd("mip_unchanged", 12'h344, 32'd0);
        rd("mvendorid", 12'hF11, 32'd0);

        // Synchronous exception in direct mode, then MRET.
        wr(2'b01, 12'h300, 32'h0000_0008);
        wr(2'b01, 12'h305, 32'h0000_1003);
        rd("mtvec_bit1", 12'h305, 32'h0000_1001);
        wr(2'b01, 12'h305, 32'h0000_1000);
        rd("mstatus_mie", 12'h300, 32'h0000_1808);
        bus.e_raised = 1'b1; bus.e_cause = 4'd2; bus.e_pc = 32'h100; bus.e_tval = 32'hDEAD;
        chk("exc_taken", K_TT, 32'd1);
        chk("exc_pc", K_TPC, 32'h0000_1000);
        cyc();
        bus.e_raised = 1'b0;
        chk("exc_mepc_out", K_MEPC, 32'h100);
        rd("exc_mepc", 12'h341, 32'h100);
        rd("exc_mcause", 12'h342, 32'd2);
        rd("exc_mtval", 12'h343, 32'hDEAD);
        rd("exc_mstatus", 12'h300, 32'h0000_1880);
        bus.is_mret = 1'b1;
        chk("mret_no_trap", K_TT, 32'd0);
        cyc();
        bus.is_mret = 1'b0;
        rd("mret_mstatus", 12'h300, 32'h0000_1888);

        // Vectored interrupts and exception-over-interrupt priority.
        wr(2'b01, 12'h305, 32'h0000_2001);
        wr(2'b01, 12'h304, 32'hFFFF_FFFF);
        rd("mie_mask", 12'h304, 32'h0000_0888);
        wr(2'b01, 12'h304, 32'h0000_0880);
        bus.irq_timer = 1'b1; bus.irq_ext = 1'b1;
        cyc();
        chk("no_window", K_TT, 32'd0);
        rd("mip_irqs", 12'h344, 32'h0000_0880);
        bus.int_window = 1'b1; bus.int_pc = 32'h300;
        bus.e_raised = 1'b1; bus.e_cause = 4'd5; bus.e_pc = 32'h200; bus.e_tval = 32'h55;
        chk("exc_wins_taken", K_TT, 32'd1);
        chk("exc_wins_pc", K_TPC, 32'h0000_2000);
        cyc();
        bus.e_raised = 1'b0; bus.int_window = 1'b0;
        rd("exc_wins_mcause", 12'h342, 32'd5);
        rd("exc_wins_mepc", 12'h341, 32'h200);
        bus.is_mret = 1'b1;
        cyc();
        bus.is_mret = 1'b0;
        bus.int_window = 1'b1;
        chk("mei_taken", K_TT, 32'd1);
        chk("mei_vec_pc", K_TPC, 32'h0000_202C);
        cyc();
        bus.int_window = 1'b0;
        rd("mei_mcause", 12'h342, 32'h8000_000B);
        rd("mei_mtval", 12'h343, 32'd0);
        rd("mei_mepc", 12'h341, 32'h300);
        rd("mei_mstatus", 12'h300, 32'h0000_1880);

        // MSI outranks MTI.
        wr(2'b01, 12'h304, 32'h0000_0888);
        bus.irq_ext = 1'b0; bus.irq_sw = 1'b1; bus.is_mret = 1'b1;
        cyc();
        bus.is_mret = 1'b0;
        bus.int_window = 1'b1; bus.int_pc = 32'h304;
        chk("msi_taken", K_TT, 32'd1);
        chk("msi_vec_pc", K_TPC, 32'h0000_200C);
        cyc();
        bus.int_window = 1'b0; bus.irq_sw = 1'b0; bus.irq_timer = 1'b0;
        rd("msi_mcause", 12'h342, 32'h8000_0003);

        // mcycle carry into the high half.
        wr(2'b01, 12'hB00, 32'hFFFF_FFFE);
        wr(2'b01, 12'hB80, 32'd0);
        rd("cy_lo_fe", 12'hB00, 32'hFFFF_FFFE);
        rd("cy_hi_0", 12'hB80, 32'd0);
        rd("cy_lo_wrap", 12'hB00, 32'd0);
        rd("cy_hi_carry", 12'hC80, 32'd1);

        // minstret counting and inhibit.
        bus.instret = 1'b1;
        wr(2'b01, 12'hB02, 32'd5);
        rd("ir_written", 12'hB02, 32'd5);
        wr(2'b10, 12'h320, 32'd4);
        rd("ir_frozen", 12'hB02, 32'd7);
        rd("ir_frozen_shadow", 12'hC02, 32'd7);
        rd("inhibit_read", 12'h320, 32'd4);
        rd("ir_hi", 12'hB82, 32'd0);
        bus.instret = 1'b0;

        // Same-cycle conflicts: MRET beats a CSR write; a trap beats an mepc write.
        wr(2'b01, 12'h300, 32'h0000_0080);
        bus.is_mret = 1'b1;
        wr(2'b01, 12'h300, 32'd0);
        bus.is_mret = 1'b0;
        rd("mret_beats_write", 12'h300, 32'h0000_1888);
        bus.e_raised = 1'b1; bus.e_cause = 4'd3; bus.e_pc = 32'h400; bus.e_tval = 32'd0;
        bus.csr_op = 2'b01; bus.csr_wr_addr = 12'h341; bus.csr_src = 32'h0001_2344;
        chk("trap_wr_illegal", K_ILL, 32'd0);
        chk("trap_wr_taken", K_TT, 32'd1);
        cyc();
        bus.csr_op = 2'b00;
        bus.e_raised = 1'b0;
        chk("trap_beats_mepc_out", K_MEPC, 32'h400);
        rd("trap_beats_mepc", 12'h341, 32'h400);
        bus.e_raised = 1'b1; bus.e_pc = 32'h500;
        wr(2'b01, 12'h340, 32'h0000_ABCD);
        bus.e_raised = 1'b0;
        rd("trap_keeps_mscratch", 12'h340, 32'h0000_ABCD);
        rd("trap_mscratch_mepc", 12'h341, 32'h500);

        // Asynchronous reset mid-write.
        bus.csr_addr = 12'h340;
        bus.csr_op = 2'b01; bus.csr_wr_addr = 12'h340; bus.csr_src = 32'h1;
        rst_n = 1'b0;
        chk("async_rst_clear", K_OUT, 32'd0);
        cyc();
        rst_n = 1'b1;
        bus.csr_op = 2'b00;
        rd("post_rst_mscratch", 12'h340, 32'd0);
        rd("post_rst_mcause", 12'h342, 32'd0);
        rd("post_rst_mtvec", 12'h305, 32'd0);

        cyc();
        cyc();
        n_checks = n_checks + 1;
        if (bus.mepc_out !== 32'h0001_0000) begin
            n_fail = n_fail + 1;
            $display("FAIL final_mepc_out: got %h expected %h", bus.mepc_out, 32'h0001_0000);
        end
        n_checks = n_checks + 1;
        if (bus.trap_taken !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL final_trap_taken: got %b expected 0", bus.trap_taken);
        end
        n_checks = n_checks + 1;
        if (bus.illegal_csr !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL final_illegal: got %b expected 0", bus.illegal_csr);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/m_csr_unit.md
# m_csr_unit

Parametrised machine-mode CSR unit for the RV32I pipeline. It holds the M-mode CSR state, runs CSR read-modify-write operations, counts cycles and retired instructions, and sequences trap entry for synchronous exceptions and three prioritised interrupt sources. It also handles MRET. It sits beside the ID/EX stages: the read port is combinational for ID, and state updates commit on the clock edge from the write-back and exception path.

## Interface
- HART_ID, 32'd0: value returned by mhartid (0xF14).
- MISA_VAL, 32'h4000_0100: value returned by misa (RV32I).
- CAUSE_W, 4: width of the exception cause code; must be 4 or 5.
- MEPC_RESET, 32'h0001_0000: reset value of mepc.
- MTVEC_RESET, 32'h0000_0000: reset value of mtvec.
- MTVEC_WRITABLE, 1: when 0, mtvec is read-only.
- HAS_COUNTERS, 1: when 0, the counter CSRs and mcountinhibit are unimplemented.

Ports:
- clk  in  1  clock. Single clock domain.
- rst_n  in  1  reset. Asynchronous, active-low.
- csr_addr  in  12  read address.
- csr_out  out  32  read data. Combinational. Unimplemented addresses read 0.
- csr_wr_addr  in  12  address for the read-modify-write operation.
- csr_op  in  2  operation: 00 none, 01 write, 10 set, 11 clear.
- csr_src  in  32  operand for csr_op.
- illegal_csr  out  1  combinational. Flags an illegal access on the write port.
- instret  in  1  one instruction retired this cycle.
- irq_ext, irq_timer, irq_sw  in  1 each  level-sensitive interrupt requests.
- int_window  in  1  the pipeline can take an interrupt this cycle.
- int_pc  in  32  resume PC saved to mepc when an interrupt is taken.
- e_raised  in  1  synchronous exception this cycle.
- e_cause  in  CAUSE_W  exception code.
- e_pc, e_tval  in  32 each  faulting PC and trap value.
- is_mret  in  1  MRET commits this cycle.
- trap_taken  out  1  combinational. High when an exception or interrupt is accepted this cycle.
- trap_pc  out  32  combinational. Redirect target when trap_taken is high.
- mepc_out  out  32  current mepc, used as the MRET target.

## Operation
- New value on the write port:
  - write: csr_src.
  - set: old | csr_src.
  - clear: old & ~csr_src.
  - Set or clear with csr_src == 0 does not count as a write.
- illegal_csr conditions:
  - csr_op != 0 and csr_wr_addr is unimplemented; or
  - csr_op != 0, the operation is an effective write, and the target is read-only (csr_wr_addr[11:10] == 2'b11, or mtvec with MTVEC_WRITABLE = 0).
  - An illegal access changes no state.
- Read-only registers:
  - mvendorid, marchid, mimpid read 0.
  - mhartid reads HART_ID; misa reads MISA_VAL.
- mstatus (0x300):
  - Only MIE[3] and MPIE[7] are stored.
  - MPP[12:11] reads 2'b11. All other bits read 0.
- mie (0x304): bits 11, 7 and 3 are writable; all other bits read 0.
- mip (0x344):
  - Read-only. MEIP[11], MTIP[7], MSIP[3] are the irq_* inputs, registered once.
  - Writes to mip are ignored; they are not illegal.
- mtvec (0x305):
  - Bit 0 is the mode: 0 direct, 1 vectored. Bit 1 is hardwired to 0. Base is bits [31:2].
- mscratch (0x340), mepc (0x341), mcause (0x342), mtval (0x343):
  - All 32-bit read/write. mepc[1:0] reads 0.
- Counters, only when HAS_COUNTERS = 1:
  - mcycle/mcycleh at 0xB00/0xB80; minstret/minstreth at 0xB02/0xB82.
  - Read-only shadows cycle/cycleh at 0xC00/0xC80 and instret/instreth at 0xC02/0xC82.
  - mcountinhibit (0x320): bit 0 (CY) and bit 2 (IR) are writable.
  - Each counter is 64 bits. It increments by 1 per cycle (mcycle) or per instret (minstret) unless inhibited. The carry from the low half propagates into the high half.
  - A CSR write to either half replaces that half. In that cycle the whole counter does not increment.
- Interrupt pending:
  - ip = mip & mie, taken only if mstatus.MIE = 1.
  - Priority: MEI (11) > MSI (3) > MTI (7).
  - Accepted only when int_window = 1 and e_raised = 0.
- Trap entry:
  - Exceptions take priority over interrupts.
  - Exception: mepc ← e_pc, mcause ← {1'b0, zero-extended e_cause}, mtval ← e_tval.
  - Interrupt: mepc ← int_pc, mcause ← {1'b1, 27'd0, code}, mtval ← 0.
  - Both: MPIE ← MIE, then MIE ← 0.
- trap_pc:
  - Direct mode, or any exception: {base, 2'b00}.
  - Vectored mode with an interrupt: {base, 2'b00} + 4·code.
- MRET: MIE ← MPIE, MPIE ← 1.
- Same-cycle priority: trap > MRET > CSR write. A losing CSR write is dropped, except writes to mscratch and the counters, which still commit. The illegal_csr flag is still computed for a dropped write.

## Timing
- Reset values: mstatus 0, mie 0, mip 0, mtvec MTVEC_RESET, mepc MEPC_RESET, mcause 0, mtval 0, mscratch 0, counters 0, mcountinhibit 0.
- Combinational outputs: csr_out, trap_taken, trap_pc and illegal_csr are combinational. mepc_out is registered.
- Write latency: a CSR write commits at the next rising edge. Reads in the same cycle return the old value; there is no internal bypass.
- Interrupt latency: an irq_* assertion is visible in mip one cycle later. trap_taken can rise in that same cycle if the enables and int_window allow.
- Counter wrap: minstret and mcycle wrap from 2^64-1 to 0.
- Reset mid-operation: an asynchronous rst_n assertion clears all state immediately. Pending trap or CSR ops are lost.

## Test plan
- Reset: release rst_n, read 0x341 and 0x305 → csr_out = 32'h0001_0000 and MTVEC_RESET; mcycle reads 3 after 3 clocks.
- CSR RMW: write mscratch 32'hF0F0_00FF; set 32'h0000_FF00; clear 32'h0000_00F0 → reads 32'hF0F0_FF0F. Write 0xF11 → illegal_csr = 1 and no change. Set 0xF11 with csr_src = 0 → illegal_csr = 0.
- Exception: e_raised with e_cause 2, e_pc 32'h100, e_tval 32'hDEAD while MIE = 1 → mepc 0x100, mcause 2, mtval 32'hDEAD, MIE 0, MPIE 1, trap_pc = base. Then MRET → MIE 1.
- Vectored interrupt: mtvec = 32'h0000_2001, mie = 32'h880, MIE = 1, irq_timer and irq_ext high, int_window high → mcause 32'h8000_000B, trap_pc 32'h0000_202C, mtval 0. With e_raised in the same cycle, the exception wins.
- Counter carry: write mcycle 32'hFFFF_FFFE, mcycleh 0 → after 2 cycles mcycleh = 1 and mcycle = 0. Set mcountinhibit bit 2 with instret high → minstret frozen.
- Same-cycle conflict: MRET together with a write of 0 to mstatus → MIE takes MPIE, the write is dropped. A trap together with a write to mepc → mepc = trap PC.
